// File: rtl/sram_fifo_pkg.sv
// sram_fifo_pkg
// Shared constants and helpers for the SRAM-backed FWFT FIFO controller:
// FIFO depth and pointer width as functions of the SRAM address width, and
// the size of the prefetch output buffer.
package sram_fifo_pkg;

  // Prefetch buffer entries; two are enough to hide the 1-cycle SRAM read.
  localparam int BUF_DEPTH = 2;
  // Width of the output buffer level (0..BUF_DEPTH).
  localparam int BUF_LVL_W = 2;

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  // One extra bit distinguishes full from empty when pointers wrap.
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/sram_fifo_ctrl_if.sv
// sram_fifo_ctrl_if
// Push/pop stream handshakes of the FIFO controller.
//   wr_data/wr_valid/wr_ready : producer -> FIFO
//   rd_data/rd_valid/rd_ready : FIFO -> consumer
// Modports: slave = FIFO side, master = producer/consumer side.
interface sram_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_ready;

  modport slave (
    input  wr_data, wr_valid, rd_ready,
    output wr_ready, rd_data, rd_valid
  );

  modport master (
    output wr_data, wr_valid, rd_ready,
    input  wr_ready, rd_data, rd_valid
  );
endinterface

// File: rtl/sram_fifo_outbuf.sv
// sram_fifo_outbuf
// Two-entry prefetch/skid buffer between the SRAM read port and the pop
// interface. Entry 0 is the head and drives head; new words land at the
// tail slot after any same-cycle pop has been accounted for.
// Ports:
//   clk, rst      clock, async active-high reset
//   push          write push_data at the tail (caller guarantees room)
//   push_data     word returned by the SRAM
//   pop           remove head (ignored when empty)
//   head          current head word
//   level         number of held words (0..2)
module sram_fifo_outbuf
  import sram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [BUF_LVL_W-1:0]  level
);

  logic [DATA_WIDTH-1:0] entry [BUF_DEPTH];
  logic [BUF_LVL_W-1:0]  level_q;
  logic [BUF_LVL_W-1:0]  tail_idx;
  logic                  pop_ok;

  assign pop_ok   = pop && (level_q != '0);
  assign tail_idx = level_q - BUF_LVL_W'(pop_ok);
  assign head     = entry[0];
  assign level    = level_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q  <= '0;
      entry[0] <= '0;
      entry[1] <= '0;
    end else begin
      if (pop_ok) entry[0] <= entry[1];
      // A push after the shift overrides it when the tail is slot 0.
      if (push) begin
        if (tail_idx == '0) entry[0] <= push_data;
        else                entry[1] <= push_data;
      end
      level_q <= level_q + BUF_LVL_W'(push) - BUF_LVL_W'(pop_ok);
    end
  end

endmodule

// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl
// First-word-fall-through FIFO controller driving an external single-clock
// dual-port SRAM (1-cycle registered read). Words are written straight to
// the SRAM, fetched back in order into a 2-entry output buffer and presented
// on the pop interface at one word per cycle.
// Ports:
//   clk, rst         clock, async active-high reset
//   bus (slave)      push (wr_*) and pop (rd_*) handshakes
//   count            words held: SRAM + in-flight read + output buffer
//   mem_data/mem_write_addr/mem_we   SRAM write port
//   mem_read_addr/mem_q              SRAM read port (q one cycle later)
// Optional: SRAM_FIFO_ALMOST_EN adds registered almost_full / almost_empty.
module sram_fifo_ctrl
  import sram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 8,
  parameter int ALMOST_MARGIN = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_fifo_ctrl_if.slave       bus,
  output logic [ADDR_WIDTH:0]   count,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_q
`ifdef SRAM_FIFO_ALMOST_EN
  ,
  output logic                  almost_full,
  output logic                  almost_empty
`endif
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);
  localparam int PW    = ptr_width(ADDR_WIDTH);

  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        mem_level;
  logic [PW-1:0]        count_next;
  logic                 inflight;
  logic                 push;
  logic                 pop;
  logic                 fetch;
  logic [BUF_LVL_W-1:0] buf_level;
  logic [2:0]           occupancy;

  assign bus.wr_ready = !rst && (count != PW'(DEPTH));
  assign bus.rd_valid = (buf_level != '0);

  assign push = bus.wr_valid && bus.wr_ready;
  assign pop  = bus.rd_valid && bus.rd_ready;

  assign mem_we         = push;
  assign mem_data       = bus.wr_data;
  assign mem_write_addr = wr_ptr[ADDR_WIDTH-1:0];
  assign mem_read_addr  = rd_ptr[ADDR_WIDTH-1:0];

  // Registered pointers only: a word written this cycle is not yet visible
  // to the fetch logic, so the SRAM's old-data collision never matters.
  assign mem_level = wr_ptr - rd_ptr;

  // Buffer slots that will be committed after this edge; pop frees one.
  assign occupancy = 3'(buf_level) + 3'(inflight) - 3'(pop);
  assign fetch     = (mem_level != '0) && (occupancy < 3'(BUF_DEPTH));

  always_comb begin
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = count + PW'(1);
      2'b01:   count_next = count - PW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      inflight <= 1'b0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + PW'(1);
      if (fetch) rd_ptr <= rd_ptr + PW'(1);
      inflight <= fetch;
      count    <= count_next;
    end
  end

  sram_fifo_outbuf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_outbuf (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (mem_q),
    .pop       (pop),
    .head      (bus.rd_data),
    .level     (buf_level)
  );

`ifdef SRAM_FIFO_ALMOST_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= (count_next >= PW'(DEPTH - ALMOST_MARGIN));
      almost_empty <= (count_next <= PW'(ALMOST_MARGIN));
    end
  end
`endif

endmodule
